// File: rtl/lcd_read_charactor_4bit.sv
// -----------------------------------------------------------------------------
// lcd_read_charactor_4bit
// Read side of an HD44780 LCD on a 4-bit bus. It performs a status read
// (RS=0: busy flag and address counter) or a data read (RS=1: DDRAM/CGRAM).
// Each read uses two E strobes: the upper nibble first, then the lower nibble.
// In busy-wait mode the status read repeats until BF clears or the poll
// limit is reached.
//
// Parameters
//   SETUP_CYC   cycles from RS/RW valid to the first E rise
//   E_HIGH_CYC  cycles E is held high per strobe (data sampled as E falls)
//   E_LOW_CYC   cycles E is held low after each strobe
//   MAX_POLLS   number of extra status re-reads allowed while BF=1 (1..255)
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous reset, active low
//   req          in   start a read (accepted only while ready=1)
//   sel_data     in   0 = status read, 1 = data read
//   wait_busy    in   with sel_data=0: repeat the read while BF=1
//   ready        out  idle and able to accept req
//   valid        out  one-cycle pulse, rd_byte is valid
//   rd_byte      out  byte read {upper nibble, lower nibble}
//   busy_flag    out  BF from the last status read
//   addr_count   out  address counter from the last status read
//   timeout      out  poll limit reached while BF was still 1 (set with valid)
//   rd_active    out  read in progress; the top level tristates D4-D7
//   rs, rw, e    out  LCD control lines
//   lcd_data_in  in   D4-D7 as driven by the LCD
// -----------------------------------------------------------------------------
module lcd_read_charactor_4bit #(
    parameter int SETUP_CYC  = 2,
    parameter int E_HIGH_CYC = 4,
    parameter int E_LOW_CYC  = 4,
    parameter int MAX_POLLS  = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       sel_data,
    input  logic       wait_busy,
    output logic       ready,
    output logic       valid,
    output logic [7:0] rd_byte,
    output logic       busy_flag,
    output logic [6:0] addr_count,
    output logic       timeout,
    output logic       rd_active,
    output logic       rs,
    output logic       rw,
    output logic       e,
    input  logic [3:0] lcd_data_in
);

    // state    | meaning
    // ---------+-----------------------------------------------------------
    // ST_IDLE  | waiting for req; ready=1
    // ST_SETUP | RS/RW driven, E low, address setup time
    // ST_E1_HI | E high for the upper nibble
    // ST_E1_LO | E low after the upper nibble (captured on entry)
    // ST_E2_HI | E high for the lower nibble
    // ST_E2_LO | E low after the lower nibble; then re-poll or finish
    // ST_DONE  | valid=1 for one cycle, RS/RW released
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_E1_HI = 3'd2,
        ST_E1_LO = 3'd3,
        ST_E2_HI = 3'd4,
        ST_E2_LO = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam logic [7:0] LD_SETUP = 8'(SETUP_CYC - 1);
    localparam logic [7:0] LD_HIGH  = 8'(E_HIGH_CYC - 1);
    localparam logic [7:0] LD_LOW   = 8'(E_LOW_CYC - 1);
    localparam logic [7:0] POLL_MAX = 8'(MAX_POLLS);

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_cnt;
    logic [7:0] w_cnt_load;
    logic       w_tc;

    logic       r_sel;
    logic       r_wait;
    logic [7:0] r_polls;
    logic [3:0] r_hi;
    logic [3:0] r_lo;
    logic [7:0] r_rd_byte;
    logic       r_busy_flag;
    logic [6:0] r_addr_count;
    logic       r_timeout;

    logic       w_accept;
    logic       w_cap_hi;
    logic       w_cap_lo;
    logic       w_end_read;
    logic       w_repoll;
    logic       w_finish;

    // Phase timer: a down-counter loaded on every state change with the
    // new state's duration minus one; the state ends at terminal count.
    assign w_tc = (r_cnt == 8'd0);

    // BF is bit 3 of the upper nibble captured during this read.
    assign w_repoll   = r_wait & ~r_sel & r_hi[3] & (r_polls < POLL_MAX);

    assign w_accept   = (r_state == ST_IDLE)  && req;
    assign w_cap_hi   = (r_state == ST_E1_HI) && w_tc;
    assign w_cap_lo   = (r_state == ST_E2_HI) && w_tc;
    assign w_end_read = (r_state == ST_E2_LO) && w_tc;
    assign w_finish   = w_end_read && !w_repoll;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (req)  w_state_nxt = ST_SETUP;
            ST_SETUP: if (w_tc) w_state_nxt = ST_E1_HI;
            ST_E1_HI: if (w_tc) w_state_nxt = ST_E1_LO;
            ST_E1_LO: if (w_tc) w_state_nxt = ST_E2_HI;
            ST_E2_HI: if (w_tc) w_state_nxt = ST_E2_LO;
            ST_E2_LO: if (w_tc) w_state_nxt = w_repoll ? ST_SETUP : ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_load = 8'd0;
        case (w_state_nxt)
            ST_SETUP:           w_cnt_load = LD_SETUP;
            ST_E1_HI, ST_E2_HI: w_cnt_load = LD_HIGH;
            ST_E1_LO, ST_E2_LO: w_cnt_load = LD_LOW;
            default:            w_cnt_load = 8'd0;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt        <= 8'd0;
            r_sel        <= 1'b0;
            r_wait       <= 1'b0;
            r_polls      <= 8'd0;
            r_hi         <= 4'd0;
            r_lo         <= 4'd0;
            r_rd_byte    <= 8'd0;
            r_busy_flag  <= 1'b0;
            r_addr_count <= 7'd0;
            r_timeout    <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_cnt <= w_cnt_load;
            end else if (!w_tc) begin
                r_cnt <= r_cnt - 8'd1;
            end

            if (w_accept) begin
                r_sel   <= sel_data;
                r_wait  <= wait_busy;
                r_polls <= 8'd0;
            end

            // Sample on the clock edge where E goes low.
            if (w_cap_hi) begin
                r_hi <= lcd_data_in;
            end
            if (w_cap_lo) begin
                r_lo <= lcd_data_in;
            end

            if (w_end_read && w_repoll) begin
                r_polls <= r_polls + 8'd1;
            end

            if (w_finish) begin
                r_rd_byte <= {r_hi, r_lo};
                if (!r_sel) begin
                    r_busy_flag  <= r_hi[3];
                    r_addr_count <= {r_hi[2:0], r_lo};
                end
                // Finishing a busy-wait status read with BF still set can
                // only mean the poll budget ran out.
                r_timeout <= r_wait & ~r_sel & r_hi[3];
            end
        end
    end

    // -------------------------------------------------------------- outputs
    // Control lines decode straight from the state register, so RS/RW can
    // only change on state boundaries where E is already low.
    always_comb begin
        ready     = (r_state == ST_IDLE);
        valid     = (r_state == ST_DONE);
        rd_active = (r_state != ST_IDLE);
        e         = (r_state == ST_E1_HI) || (r_state == ST_E2_HI);
        rw        = (r_state == ST_SETUP) || (r_state == ST_E1_HI) ||
                    (r_state == ST_E1_LO) || (r_state == ST_E2_HI) ||
                    (r_state == ST_E2_LO);
        rs        = rw & r_sel;
    end

    assign rd_byte    = r_rd_byte;
    assign busy_flag  = r_busy_flag;
    assign addr_count = r_addr_count;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_lcd_read_charactor_4bit.sv
module tb_lcd_read_charactor_4bit;

    localparam int S  = 2;
    localparam int H  = 4;
    localparam int L  = 4;
    localparam int MP = 3;
    localparam int P  = S + 2*H + 2*L;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req = 1'b0;
    logic       sel_data = 1'b0;
    logic       wait_busy = 1'b0;
    logic [3:0] lcd_data_in = 4'hE;
    logic       ready, valid, busy_flag, timeout, rd_active, rs, rw, e;
    logic [7:0] rd_byte;
    logic [6:0] addr_count;

    lcd_read_charactor_4bit #(
        .SETUP_CYC(S), .E_HIGH_CYC(H), .E_LOW_CYC(L), .MAX_POLLS(MP)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .sel_data(sel_data),
        .wait_busy(wait_busy), .ready(ready), .valid(valid),
        .rd_byte(rd_byte), .busy_flag(busy_flag), .addr_count(addr_count),
        .timeout(timeout), .rd_active(rd_active), .rs(rs), .rw(rw), .e(e),
        .lcd_data_in(lcd_data_in)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Bytes the simulated LCD returns, one per read of a transaction.
    logic [7:0] scr[$];

    // LCD model: presents the next nibble when E rises, junk while E is low.
    int   lcd_s = 0;
    bit   e_d = 1'b0;
    logic [7:0] lcd_b;
    always @(negedge clk) begin
        if (ready) lcd_s = 0;
        if (e && !e_d) begin
            lcd_b = scr[lcd_s / 2];
            lcd_data_in = (lcd_s % 2 == 1) ? lcd_b[3:0] : lcd_b[7:4];
            lcd_s++;
        end else if (!e) begin
            lcd_data_in = 4'hE;
        end
        e_d = e;
    end

    // Transaction-level model: a transaction of n reads lasts n*P cycles after
    // the accept edge, then one valid cycle, then idle.
    bit         m_act = 1'b0;
    int         m_t = 0;
    int         m_n = 1;
    bit         m_sel = 1'b0;
    logic [7:0] m_fin = 8'h00;
    bit         m_fin_to = 1'b0;
    logic [7:0] m_rd_byte = 8'h00;
    bit         m_bf = 1'b0;
    logic [6:0] m_ac = 7'h00;
    bit         m_to = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            m_act = 1'b0; m_t = 0; m_rd_byte = 8'h00;
            m_bf = 1'b0; m_ac = 7'h00; m_to = 1'b0;
        end else if (!m_act) begin
            if (req) begin
                m_act = 1'b1; m_t = 0; m_sel = sel_data;
                if (sel_data || !wait_busy) begin
                    m_n = 1;
                end else begin
                    m_n = MP + 1;
                    for (int i = 0; i <= MP; i++) begin
                        if (!scr[i][7]) begin
                            m_n = i + 1;
                            break;
                        end
                    end
                end
                m_fin = scr[m_n - 1];
                m_fin_to = !sel_data && wait_busy && m_fin[7];
            end
        end else begin
            m_t++;
            if (m_t == m_n * P) begin
                m_rd_byte = m_fin;
                if (!m_sel) begin
                    m_bf = m_fin[7];
                    m_ac = m_fin[6:0];
                end
                m_to = m_fin_to;
            end else if (m_t > m_n * P) begin
                m_act = 1'b0;
            end
        end
    end

    bit in_txn, exp_e, exp_valid;
    int ph;
    always @(negedge clk) begin
        if (cmp_en) begin
            in_txn    = m_act && (m_t < m_n * P);
            ph        = m_t % P;
            exp_e     = in_txn && ((ph >= S && ph < S + H) ||
                                   (ph >= S + H + L && ph < S + 2*H + L));
            exp_valid = m_act && (m_t == m_n * P);
            chk("ready",      ready,      !m_act);
            chk("rd_active",  rd_active,  m_act);
            chk("rw",         rw,         in_txn);
            chk("rs",         rs,         in_txn && m_sel);
            chk("e",          e,          exp_e);
            chk("valid",      valid,      exp_valid);
            chk("rd_byte",    rd_byte,    m_rd_byte);
            chk("busy_flag",  busy_flag,  m_bf);
            chk("addr_count", addr_count, m_ac);
            if (exp_valid) chk("timeout", timeout, m_to);
        end
    end

    task automatic wait_ready();
        int c = 0;
        while (!ready && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("wait_ready", ready, 1);
    endtask

    // Start one read (script already in scr), return cycles to valid and E pulses.
    task automatic do_read(input bit sel, input bit wb, output int t, output int pulses);
        bit got = 1'b0;
        bit ep = 1'b0;
        wait_ready();
        sel_data = sel; wait_busy = wb; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        t = 0; pulses = 0;
        while (!got && t < 500) begin
            if (e && !ep) pulses++;
            ep = e;
            if (valid) got = 1'b1;
            else begin
                @(negedge clk);
                t++;
            end
        end
        chk("valid_seen", got, 1);
    endtask

    int t_v, np, c_rw, c_val, v1, v2, r2, cyc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        scr = '{8'h00};
        reset = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_ready", ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_rw", rw, 0);
        chk("rst_e", e, 0);
        chk("rst_rd_active", rd_active, 0);
        chk("rst_rd_byte", rd_byte, 8'h00);
        reset = 1'b1;
        @(negedge clk);

        // Data read
        scr = '{8'h41};
        do_read(1'b1, 1'b0, t_v, np);
        chk("data_latency", t_v, 18);
        chk("data_pulses", np, 2);
        chk("data_byte", rd_byte, 8'h41);
        chk("data_bf_kept", busy_flag, 0);

        // Status read
        scr = '{8'h2A};
        do_read(1'b0, 1'b0, t_v, np);
        chk("stat_pulses", np, 2);
        chk("stat_ac", addr_count, 7'h2A);
        chk("stat_bf", busy_flag, 0);
        chk("stat_to", timeout, 0);

        // Data read with wait_busy set: no polling, status left alone
        scr = '{8'hC4};
        do_read(1'b1, 1'b1, t_v, np);
        chk("data_wb_pulses", np, 2);
        chk("data_wb_ac_kept", addr_count, 7'h2A);

        // Status read with BF=1 but no busy wait
        scr = '{8'hA3};
        do_read(1'b0, 1'b0, t_v, np);
        chk("stat_bf1_pulses", np, 2);
        chk("stat_bf1_bf", busy_flag, 1);
        chk("stat_bf1_to", timeout, 0);

        // Busy wait: three busy reads then ready
        scr = '{8'h80, 8'h91, 8'hFF, 8'h05};
        do_read(1'b0, 1'b1, t_v, np);
        chk("bw_latency", t_v, 72);
        chk("bw_pulses", np, 8);
        chk("bw_byte", rd_byte, 8'h05);
        chk("bw_to", timeout, 0);

        // Timeout: BF stuck at 1
        scr = '{8'hFF, 8'h85, 8'hC0, 8'h9A};
        do_read(1'b0, 1'b1, t_v, np);
        chk("to_latency", t_v, 72);
        chk("to_pulses", np, 8);
        chk("to_flag", timeout, 1);
        chk("to_bf", busy_flag, 1);
        chk("to_ac", addr_count, 7'h1A);

        // req pulses while busy are ignored
        wait_ready();
        scr = '{8'h41};
        sel_data = 1'b1; wait_busy = 1'b0; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            @(negedge clk);
            req = (i == 5 || i == 17 || i == 18);
        end
        req = 1'b0;
        c_rw = 0;
        repeat (30) begin
            @(negedge clk);
            if (rw) c_rw++;
        end
        chk("ignored_req_rw", c_rw, 0);

        // req held high: back-to-back reads with one turnaround cycle
        scr = '{8'h41};
        sel_data = 1'b1; wait_busy = 1'b0; req = 1'b1;
        v1 = -1; v2 = -1; r2 = -1; cyc = 0;
        while (v2 < 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (valid && v1 < 0) v1 = cyc;
            else if (valid && v1 >= 0) v2 = cyc;
            if (v1 >= 0 && r2 < 0 && rw) r2 = cyc;
            if (v1 >= 0 && cyc == v1 + 1) chk("gap_ready", ready, 1);
        end
        req = 1'b0;
        chk("b2b_next_rw", r2 - v1, 2);
        chk("b2b_period", v2 - v1, 20);

        // Reset in the middle of strobe 1
        wait_ready();
        scr = '{8'h77};
        sel_data = 1'b1; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        cyc = 0;
        while (!e && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_e_seen", e, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_e", e, 0);
        chk("mid_rst_rw", rw, 0);
        chk("mid_rst_active", rd_active, 0);
        chk("mid_rst_ready", ready, 1);
        reset = 1'b1;
        c_val = 0;
        repeat (30) begin
            @(negedge clk);
            if (valid) c_val++;
        end
        chk("mid_no_valid", c_val, 0);
        chk("mid_rd_byte", rd_byte, 8'h00);

        // Recovery after reset
        scr = '{8'h2A};
        do_read(1'b0, 1'b0, t_v, np);
        chk("rec_latency", t_v, 18);
        chk("rec_ac", addr_count, 7'h2A);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
